misc_issue_queue: RTL and testbench



---
 rtl/misc_issue_queue_pkg.sv | 49 ++++
 rtl/misc_iq_wakeup.sv | 23 ++
 rtl/misc_issue_queue.sv | 119 +++++++++++
 tb/tb_misc_issue_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/misc_issue_queue_pkg.sv
// Shared types for the misc-pipe issue queue: the entry payload, the op
// encodings and the default sizing.
package misc_issue_queue_pkg;

  localparam int DEPTH_DEF      = 8;
  localparam int DISP_WIDTH_DEF = 2;
  localparam int WAKE_NUM_DEF   = 4;
  localparam int PREG_W_DEF     = 6;
  localparam int ROB_W_DEF      = 6;

  typedef enum logic [1:0] {
    ALU_INST  = 2'd0,
    BR_INST   = 2'd1,
    MEM_INST  = 2'd2,
    PRIV_INST = 2'd3
  } instr_type_e;

  typedef enum logic [3:0] {
    MISC_BRANCH    = 4'd0,
    MISC_JUMP      = 4'd1,
    MISC_CSR_READ  = 4'd2,
    MISC_CSR_WRITE = 4'd3,
    MISC_CSR_XCHG  = 4'd4,
    MISC_TLB       = 4'd5,
    MISC_CACOP     = 4'd6,
    MISC_ERET      = 4'd7,
    MISC_IDLE      = 4'd8
  } misc_op_e;

  typedef struct packed {
    logic [ROB_W_DEF-1:0]  rob_idx;
    logic [31:0]           pc;
    logic [31:0]           npc;
    logic [31:0]           imm;
    logic [PREG_W_DEF-1:0] psrc0;
    logic [PREG_W_DEF-1:0] psrc1;
    logic                  src0_rdy;
    logic                  src1_rdy;
    logic [PREG_W_DEF-1:0] pdest;
    instr_type_e           instr_type;
    misc_op_e              misc_op;
  } misc_iq_entry_t;

  // Privileged ops must wait until they are the oldest instruction in the ROB.
  function automatic logic is_serial(instr_type_e t);
    return t == PRIV_INST;
  endfunction

endpackage

// File: rtl/misc_iq_wakeup.sv
// Matches one entry's two source registers against every wakeup port.
module misc_iq_wakeup #(
  parameter int WAKE_NUM = 4,
  parameter int PREG_W   = 6
) (
  input  logic [PREG_W-1:0]                psrc0,
  input  logic [PREG_W-1:0]                psrc1,
  input  logic [WAKE_NUM-1:0]              wake_valid,
  input  logic [WAKE_NUM-1:0][PREG_W-1:0]  wake_preg,
  output logic                             hit0,
  output logic                             hit1
);

  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int w = 0; w < WAKE_NUM; w++) begin
      if (wake_valid[w] && (wake_preg[w] == psrc0)) hit0 = 1'b1;
      if (wake_valid[w] && (wake_preg[w] == psrc1)) hit1 = 1'b1;
    end
  end

endmodule

// File: rtl/misc_issue_queue.sv
// In-order issue queue for the misc pipe: circular buffer, wakeup tracking,
// head-only issue, privileged ops held until they reach the ROB head.
module misc_issue_queue
  import misc_issue_queue_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DISP_WIDTH = DISP_WIDTH_DEF,
  parameter int WAKE_NUM   = WAKE_NUM_DEF,
  parameter int PREG_W     = PREG_W_DEF,
  parameter int ROB_W      = ROB_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [DISP_WIDTH-1:0]              disp_valid_i,
  input  misc_iq_entry_t [DISP_WIDTH-1:0]    disp_i,
  output logic                               disp_ready_o,
  input  logic [WAKE_NUM-1:0]                wake_valid_i,
  input  logic [WAKE_NUM-1:0][PREG_W-1:0]    wake_preg_i,
  input  logic                               rob_head_valid_i,
  input  logic [ROB_W-1:0]                   rob_head_idx_i,
  output logic                               issue_valid_o,
  output misc_iq_entry_t                     issue_o,
  input  logic                               issue_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  misc_iq_entry_t       entries_q [DEPTH];
  logic [DEPTH-1:0]     serial_q;
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [CNT_W-1:0]     count_q;

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_hit0;
  logic [DEPTH-1:0]      ent_hit1;
  logic [DISP_WIDTH-1:0] lane_hit0;
  logic [DISP_WIDTH-1:0] lane_hit1;
  logic [PTR_W-1:0]      lane_off [DISP_WIDTH];
  misc_iq_entry_t        disp_ent [DISP_WIDTH];
  logic [CNT_W-1:0]      accepted;
  misc_iq_entry_t        head_ent;
  logic                  issue_fire;

  // Full/empty comes from count alone; pointer equality is ambiguous.
  assign disp_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(DISP_WIDTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
    misc_iq_wakeup #(.WAKE_NUM(WAKE_NUM), .PREG_W(PREG_W)) u_wake (
      .psrc0      (entries_q[i].psrc0),
      .psrc1      (entries_q[i].psrc1),
      .wake_valid (wake_valid_i),
      .wake_preg  (wake_preg_i),
      .hit0       (ent_hit0[i]),
      .hit1       (ent_hit1[i])
    );
  end

  for (genvar k = 0; k < DISP_WIDTH; k++) begin : g_lane
    misc_iq_wakeup #(.WAKE_NUM(WAKE_NUM), .PREG_W(PREG_W)) u_wake (
      .psrc0      (disp_i[k].psrc0),
      .psrc1      (disp_i[k].psrc1),
      .wake_valid (wake_valid_i),
      .wake_preg  (wake_preg_i),
      .hit0       (lane_hit0[k]),
      .hit1       (lane_hit1[k])
    );
  end

  // Valid lanes pack densely from tail; offset is the count of older valid lanes.
  always_comb begin
    accepted = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      lane_off[k] = accepted[PTR_W-1:0];
      if (disp_valid_i[k]) accepted = accepted + CNT_W'(1);
      disp_ent[k] = disp_i[k];
      disp_ent[k].src0_rdy = disp_i[k].src0_rdy | (disp_i[k].psrc0 == '0) | lane_hit0[k];
      disp_ent[k].src1_rdy = disp_i[k].src1_rdy | (disp_i[k].psrc1 == '0) | lane_hit1[k];
    end
    if (!disp_ready_o) accepted = '0;
  end

  always_comb begin
    head_ent      = entries_q[head_q];
    issue_valid_o = (count_q != '0) & head_ent.src0_rdy & head_ent.src1_rdy &
                    (~serial_q[head_q] |
                     (rob_head_valid_i & (rob_head_idx_i == head_ent.rob_idx)));
    issue_o       = issue_valid_o ? head_ent : '0;
    issue_fire    = issue_valid_o & issue_ready_i;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      serial_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && ent_hit0[i]) entries_q[i].src0_rdy <= 1'b1;
        if (ent_valid[i] && ent_hit1[i]) entries_q[i].src1_rdy <= 1'b1;
      end
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (disp_ready_o && disp_valid_i[k]) begin
          entries_q[tail_q + lane_off[k]] <= disp_ent[k];
          serial_q[tail_q + lane_off[k]]  <= is_serial(disp_ent[k].instr_type);
        end
      end
      tail_q  <= tail_q + accepted[PTR_W-1:0];
      head_q  <= head_q + PTR_W'(issue_fire);
      count_q <= count_q + accepted - CNT_W'(issue_fire);
    end
  end

endmodule

// File: tb/tb_misc_issue_queue.sv
// Bench for misc_issue_queue: directed scenarios then random traffic,
// checked every cycle against a queue-based program-order model.
module tb_misc_issue_queue;
  import misc_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int DISP  = 2;
  localparam int WN    = 4;
  localparam int EW    = $bits(misc_iq_entry_t);

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [DISP-1:0]               disp_valid;
  misc_iq_entry_t [DISP-1:0]     disp;
  logic                          disp_ready;
  logic [WN-1:0]                 wake_valid;
  logic [WN-1:0][PREG_W_DEF-1:0] wake_preg;
  logic                          rob_head_valid;
  logic [ROB_W_DEF-1:0]          rob_head_idx;
  logic                          issue_valid;
  misc_iq_entry_t                issue;
  logic                          issue_ready;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  misc_issue_queue #(
    .DEPTH(DEPTH), .DISP_WIDTH(DISP), .WAKE_NUM(WN),
    .PREG_W(PREG_W_DEF), .ROB_W(ROB_W_DEF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .disp_valid_i     (disp_valid),
    .disp_i           (disp),
    .disp_ready_o     (disp_ready),
    .wake_valid_i     (wake_valid),
    .wake_preg_i      (wake_preg),
    .rob_head_valid_i (rob_head_valid),
    .rob_head_idx_i   (rob_head_idx),
    .issue_valid_o    (issue_valid),
    .issue_o          (issue),
    .issue_ready_i    (issue_ready)
  );

  // clock
  always #5 clk = ~clk;

  function automatic bit wake_hit(logic [PREG_W_DEF-1:0] p);
    for (int w = 0; w < WN; w++)
      if (wake_valid[w] && wake_preg[w] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic misc_iq_entry_t mk(instr_type_e t, misc_op_e op, int rob,
                                        int p0, int p1, bit r0, bit r1);
    misc_iq_entry_t e;
    e.rob_idx    = ROB_W_DEF'(rob);
    e.pc         = $urandom;
    e.npc        = e.pc + 32'd4;
    e.imm        = $urandom;
    e.psrc0      = PREG_W_DEF'(p0);
    e.psrc1      = PREG_W_DEF'(p1);
    e.src0_rdy   = r0;
    e.src1_rdy   = r1;
    e.pdest      = PREG_W_DEF'($urandom_range(1, 63));
    e.instr_type = t;
    e.misc_op    = op;
    return e;
  endfunction

  function automatic bit model_issue_valid();
    misc_iq_entry_t f;
    if (exp_q.size() == 0) return 1'b0;
    f = exp_q[0];
    return f.src0_rdy && f.src1_rdy &&
           (f.instr_type != PRIV_INST || (rob_head_valid && rob_head_idx == f.rob_idx));
  endfunction

  task automatic idle_inputs();
    flush      = 1'b0;
    disp_valid = '0;
    disp       = '0;
    wake_valid = '0;
    wake_preg  = '0;
  endtask

  // One cycle: compare outputs against the model, clock, advance the model.
  task automatic tick();
    bit             ev;
    bit             er;
    misc_iq_entry_t ee;
    misc_iq_entry_t t;
    #1;
    ev = model_issue_valid();
    er = (DEPTH - exp_q.size()) >= DISP;
    ee = ev ? misc_iq_entry_t'(exp_q[0]) : '0;
    checks++;
    assert (issue_valid === ev) else begin
      errors++;
      $error("FAIL issue_valid: got %0b expected %0b", issue_valid, ev);
    end
    checks++;
    assert (issue === ee) else begin
      errors++;
      $error("FAIL issue_payload: got %h expected %h", issue, ee);
    end
    checks++;
    assert (disp_ready === er) else begin
      errors++;
      $error("FAIL disp_ready: got %0b expected %0b", disp_ready, er);
    end
    @(posedge clk);
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (ev && issue_ready) void'(exp_q.pop_front());
      foreach (exp_q[i]) begin
        t = exp_q[i];
        if (wake_hit(t.psrc0)) t.src0_rdy = 1'b1;
        if (wake_hit(t.psrc1)) t.src1_rdy = 1'b1;
        exp_q[i] = t;
      end
      if (er) begin
        for (int k = 0; k < DISP; k++) begin
          if (disp_valid[k]) begin
            t = disp[k];
            t.src0_rdy = t.src0_rdy | (t.psrc0 == '0) | wake_hit(t.psrc0);
            t.src1_rdy = t.src1_rdy | (t.psrc1 == '0) | wake_hit(t.psrc1);
            exp_q.push_back(t);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst            = 1'b1;
    issue_ready    = 1'b0;
    rob_head_valid = 1'b0;
    rob_head_idx   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();

    // reset state
    checks++;
    assert (issue_valid === 1'b0) else begin
      errors++; $error("FAIL reset_issue_valid: got %0b expected 0", issue_valid);
    end
    checks++;
    assert (issue === '0) else begin
      errors++; $error("FAIL reset_issue: got %h expected 0", issue);
    end
    checks++;
    assert (disp_ready === 1'b1) else begin
      errors++; $error("FAIL reset_disp_ready: got %0b expected 1", disp_ready);
    end

    // single ready branch: visible and issuable the next cycle
    issue_ready   = 1'b1;
    disp_valid    = 2'b01;
    disp[0]       = mk(BR_INST, MISC_BRANCH, 1, 5, 6, 1, 1);
    tick();
    idle_inputs();
    repeat (2) tick();

    // wakeup on port 2 for preg 12, no same-cycle bypass
    disp_valid = 2'b01;
    disp[0]    = mk(BR_INST, MISC_BRANCH, 2, 12, 7, 0, 1);
    tick();
    idle_inputs();
    repeat (3) tick();
    wake_valid[2] = 1'b1;
    wake_preg[2]  = 6'd12;
    tick();
    idle_inputs();
    repeat (2) tick();

    // serialized CSR write blocks a younger ready branch until ROB head matches
    rob_head_valid = 1'b1;
    rob_head_idx   = 6'd7;
    disp_valid     = 2'b11;
    disp[0]        = mk(PRIV_INST, MISC_CSR_WRITE, 9, 3, 4, 1, 1);
    disp[1]        = mk(BR_INST, MISC_BRANCH, 10, 5, 6, 1, 1);
    tick();
    idle_inputs();
    repeat (3) tick();
    rob_head_idx = 6'd9;
    repeat (3) tick();
    rob_head_valid = 1'b0;

    // fill to full under backpressure, then issue 3, refill across the wrap
    issue_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      disp_valid = 2'b11;
      disp[0]    = mk(ALU_INST, MISC_JUMP, 2 * g, $urandom_range(1, 63), 0, 1, 1);
      disp[1]    = mk(BR_INST, MISC_BRANCH, 2 * g + 1, 0, $urandom_range(1, 63), 1, 1);
      tick();
    end
    disp_valid = 2'b11;
    disp[0]    = mk(ALU_INST, MISC_JUMP, 40, 1, 1, 1, 1);
    disp[1]    = mk(ALU_INST, MISC_JUMP, 41, 1, 1, 1, 1);
    tick();
    idle_inputs();
    repeat (4) tick();
    issue_ready = 1'b1;
    repeat (3) tick();
    issue_ready = 1'b0;
    disp_valid  = 2'b11;
    disp[0]     = mk(BR_INST, MISC_BRANCH, 20, 2, 3, 1, 1);
    disp[1]     = mk(BR_INST, MISC_BRANCH, 21, 4, 5, 1, 1);
    tick();
    idle_inputs();
    issue_ready = 1'b1;
    repeat (9) tick();

    // flush beats a same-cycle dispatch and issue
    disp_valid = 2'b11;
    disp[0]    = mk(ALU_INST, MISC_JUMP, 30, 1, 2, 1, 1);
    disp[1]    = mk(ALU_INST, MISC_JUMP, 31, 3, 4, 1, 1);
    tick();
    disp[0] = mk(ALU_INST, MISC_JUMP, 32, 1, 2, 1, 1);
    disp[1] = mk(ALU_INST, MISC_JUMP, 33, 3, 4, 1, 1);
    flush   = 1'b1;
    tick();
    idle_inputs();
    repeat (2) tick();

    // random traffic
    repeat (700) begin
      idle_inputs();
      rst            = ($urandom_range(0, 199) == 0);
      flush          = ($urandom_range(0, 59) == 0);
      issue_ready    = ($urandom_range(0, 9) < 7);
      rob_head_valid = ($urandom_range(0, 9) < 7);
      rob_head_idx   = ROB_W_DEF'($urandom_range(0, 3));
      disp_valid     = DISP'($urandom_range(0, 3));
      for (int k = 0; k < DISP; k++)
        disp[k] = mk(instr_type_e'($urandom_range(0, 3)), misc_op_e'($urandom_range(0, 8)),
                     $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 1), $urandom_range(0, 1));
      for (int w = 0; w < WN; w++) begin
        wake_valid[w] = $urandom_range(0, 1);
        wake_preg[w]  = PREG_W_DEF'($urandom_range(0, 15));
      end
      tick();
    end
    rst = 1'b0;

    // drain: wake everything, open the ROB head match for any serialized op
    idle_inputs();
    issue_ready    = 1'b1;
    rob_head_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int w = 0; w < WN; w++) begin
        wake_valid[w] = 1'b1;
        wake_preg[w]  = PREG_W_DEF'((c * WN + w) % 16);
      end
      rob_head_idx = ROB_W_DEF'(c % 4);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
